// File: rtl/ls_ctrl.sv
// ============================================================================
// ls_ctrl -- load/store controller
//
// Purpose:
//   Takes one memory op at a time from the load/store buffer and works out its
//   address (vj + imm). It then runs a single request/done transaction with the
//   memory controller. For loads it sign- or zero-extends the returned data.
//   Completion is broadcast on the LS CDB for one cycle.
//
//   A ROB flush kills the op in flight:
//     - A load still waiting for memory moves to DRAIN. It waits there for the
//       pending done, then returns to IDLE without broadcasting.
//     - A store stays in MEM so the write can finish. Its broadcast is
//       suppressed.
//
// Configuration:
//   LSC_PERF_CNT_EN  when defined, enables the load/store/busy performance
//                    counters. When undefined, the counter ports are tied to 0.
//
// Ports:
//   clk_in, rst_in (async active-low), rdy_in (0 = freeze everything)
//   refresh_rob_cdb_in          ROB flush
//   rdy_lsb_in, opcode_lsb_in, vj/vk/imm_lsb_in, rob_id_lsb_in   issue side
//   idle_lsb_out                controller can accept an issue
//   req/we/addr/size/wdata_mc_out, done_mc_in, rdata_mc_in       memory side
//   rdy_cdb_out, result_cdb_out, rob_id_cdb_out                  LS CDB
//   ld_cnt_out, st_cnt_out, busy_cnt_out                         perf counters
// ============================================================================

`ifndef OP_WIDTH
`define OP_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ROB_WIDTH
`define ROB_WIDTH 4
`endif

module ls_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   refresh_rob_cdb_in,
    input  logic                   rdy_lsb_in,
    input  logic [`OP_WIDTH-1:0]   opcode_lsb_in,
    input  logic [`DATA_WIDTH-1:0] vj_lsb_in,
    input  logic [`DATA_WIDTH-1:0] vk_lsb_in,
    input  logic [`DATA_WIDTH-1:0] imm_lsb_in,
    input  logic [`ROB_WIDTH-1:0]  rob_id_lsb_in,
    output logic                   idle_lsb_out,
    output logic                   req_mc_out,
    output logic                   we_mc_out,
    output logic [ADDR_WIDTH-1:0]  addr_mc_out,
    output logic [1:0]             size_mc_out,
    output logic [`DATA_WIDTH-1:0] wdata_mc_out,
    input  logic                   done_mc_in,
    input  logic [`DATA_WIDTH-1:0] rdata_mc_in,
    output logic                   rdy_cdb_out,
    output logic [`DATA_WIDTH-1:0] result_cdb_out,
    output logic [`ROB_WIDTH-1:0]  rob_id_cdb_out,
    output logic [CNT_WIDTH-1:0]   ld_cnt_out,
    output logic [CNT_WIDTH-1:0]   st_cnt_out,
    output logic [CNT_WIDTH-1:0]   busy_cnt_out
);

    localparam logic [`OP_WIDTH-1:0] OP_LB  = `OP_WIDTH'd0;
    localparam logic [`OP_WIDTH-1:0] OP_LH  = `OP_WIDTH'd1;
    localparam logic [`OP_WIDTH-1:0] OP_LW  = `OP_WIDTH'd2;
    localparam logic [`OP_WIDTH-1:0] OP_LBU = `OP_WIDTH'd3;
    localparam logic [`OP_WIDTH-1:0] OP_LHU = `OP_WIDTH'd4;
    localparam logic [`OP_WIDTH-1:0] OP_SB  = `OP_WIDTH'd5;
    localparam logic [`OP_WIDTH-1:0] OP_SH  = `OP_WIDTH'd6;
    localparam logic [`OP_WIDTH-1:0] OP_SW  = `OP_WIDTH'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MEM   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [`OP_WIDTH-1:0]   op_q, op_d;
    logic                   idle_q, idle_d;
    logic                   req_q, req_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [1:0]             size_q, size_d;
    logic [`DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [`ROB_WIDTH-1:0]  rob_id_q, rob_id_d;
    logic                   cdb_rdy_q, cdb_rdy_d;
    logic [`DATA_WIDTH-1:0] result_q, result_d;
    logic                   flushed_q, flushed_d;

    logic [31:0]            addr_sum;
    logic                   issue_store;
    logic [1:0]             issue_size;
    logic [`DATA_WIDTH-1:0] load_ext;
    logic                   bcast;

    // Effective address wraps mod 2^32; only the low ADDR_WIDTH bits go out.
    assign addr_sum = 32'(vj_lsb_in + imm_lsb_in);

    // Decode the incoming opcode into store flag and access size.
    always_comb begin
        issue_store = 1'b0;
        issue_size  = 2'd2;
        case (opcode_lsb_in)
            OP_LB, OP_LBU: issue_size = 2'd0;
            OP_LH, OP_LHU: issue_size = 2'd1;
            OP_SB: begin issue_store = 1'b1; issue_size = 2'd0; end
            OP_SH: begin issue_store = 1'b1; issue_size = 2'd1; end
            OP_SW: begin issue_store = 1'b1; issue_size = 2'd2; end
            default: issue_size = 2'd2;
        endcase
    end

    // Extend the returned load data according to the latched opcode; stores give 0.
    always_comb begin
        load_ext = '0;
        case (op_q)
            OP_LB:  load_ext = {{(`DATA_WIDTH-8){rdata_mc_in[7]}}, rdata_mc_in[7:0]};
            OP_LBU: load_ext = {{(`DATA_WIDTH-8){1'b0}}, rdata_mc_in[7:0]};
            OP_LH:  load_ext = {{(`DATA_WIDTH-16){rdata_mc_in[15]}}, rdata_mc_in[15:0]};
            OP_LHU: load_ext = {{(`DATA_WIDTH-16){1'b0}}, rdata_mc_in[15:0]};
            OP_LW:  load_ext = rdata_mc_in;
            default: load_ext = '0;
        endcase
    end

    // Next-state logic. Nothing moves while rdy_in is low. A done pulse always
    // ends the transaction. A flush only suppresses the broadcast or diverts a
    // pending load into DRAIN, so the memory handshake is never abandoned.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        idle_d    = idle_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        rob_id_d  = rob_id_q;
        cdb_rdy_d = cdb_rdy_q;
        result_d  = result_q;
        flushed_d = flushed_q;
        bcast     = 1'b0;
        if (rdy_in) begin
            cdb_rdy_d = 1'b0;
            if (state_q == ST_IDLE) begin
                if (rdy_lsb_in && !refresh_rob_cdb_in) begin
                    state_d   = ST_MEM;
                    op_d      = opcode_lsb_in;
                    idle_d    = 1'b0;
                    req_d     = 1'b1;
                    we_d      = issue_store;
                    addr_d    = addr_sum[ADDR_WIDTH-1:0];
                    size_d    = issue_size;
                    wdata_d   = vk_lsb_in;
                    rob_id_d  = rob_id_lsb_in;
                    flushed_d = 1'b0;
                end
            end else if (done_mc_in) begin
                state_d   = ST_IDLE;
                idle_d    = 1'b1;
                req_d     = 1'b0;
                we_d      = 1'b0;
                flushed_d = 1'b0;
                if (state_q == ST_MEM && !flushed_q && !refresh_rob_cdb_in) begin
                    bcast     = 1'b1;
                    cdb_rdy_d = 1'b1;
                    result_d  = load_ext;
                end
            end else if (refresh_rob_cdb_in && state_q == ST_MEM) begin
                if (we_q) begin
                    flushed_d = 1'b1;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            idle_q    <= 1'b1;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            rob_id_q  <= '0;
            cdb_rdy_q <= 1'b0;
            result_q  <= '0;
            flushed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            idle_q    <= idle_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            rob_id_q  <= rob_id_d;
            cdb_rdy_q <= cdb_rdy_d;
            result_q  <= result_d;
            flushed_q <= flushed_d;
        end
    end

    assign idle_lsb_out   = idle_q;
    assign req_mc_out     = req_q;
    assign we_mc_out      = we_q;
    assign addr_mc_out    = addr_q;
    assign size_mc_out    = size_q;
    assign wdata_mc_out   = wdata_q;
    assign rdy_cdb_out    = cdb_rdy_q;
    assign result_cdb_out = result_q;
    assign rob_id_cdb_out = rob_id_q;

`ifdef LSC_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] ld_cnt_q, ld_cnt_d;
    logic [CNT_WIDTH-1:0] st_cnt_q, st_cnt_d;
    logic [CNT_WIDTH-1:0] busy_cnt_q, busy_cnt_d;

    // Count broadcast loads/stores and every live cycle spent in MEM or DRAIN.
    always_comb begin
        ld_cnt_d   = ld_cnt_q;
        st_cnt_d   = st_cnt_q;
        busy_cnt_d = busy_cnt_q;
        if (rdy_in) begin
            if (bcast && !we_q) ld_cnt_d = ld_cnt_q + 1'b1;
            if (bcast && we_q)  st_cnt_d = st_cnt_q + 1'b1;
            if (state_q != ST_IDLE) busy_cnt_d = busy_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            ld_cnt_q   <= '0;
            st_cnt_q   <= '0;
            busy_cnt_q <= '0;
        end else begin
            ld_cnt_q   <= ld_cnt_d;
            st_cnt_q   <= st_cnt_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign ld_cnt_out   = ld_cnt_q;
    assign st_cnt_out   = st_cnt_q;
    assign busy_cnt_out = busy_cnt_q;
`else
    assign ld_cnt_out   = '0;
    assign st_cnt_out   = '0;
    assign busy_cnt_out = '0;
`endif

endmodule

// File: tb/tb_ls_ctrl.sv
// ============================================================================
// tb_ls_ctrl -- scoreboard testbench for ls_ctrl
//
// The stimulus process issues ops and plays the memory controller. When it
// pulses done on an unflushed op, it pushes the expected CDB broadcast into a
// queue. A separate monitor pops that queue on every cycle where rdy_cdb_out
// is high. Expected load results come from plain integer arithmetic on the
// returned data.
// ============================================================================

module tb_ls_ctrl;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LH  = 4'd1;
    localparam logic [3:0] OP_LW  = 4'd2;
    localparam logic [3:0] OP_LBU = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_SB  = 4'd5;
    localparam logic [3:0] OP_SH  = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        refresh;
    logic        rdy_lsb;
    logic [3:0]  opcode;
    logic [31:0] vj, vk, imm;
    logic [3:0]  rob_id_in;
    logic        idle_out;
    logic        req_out, we_out;
    logic [31:0] addr_out;
    logic [1:0]  size_out;
    logic [31:0] wdata_out;
    logic        done;
    logic [31:0] rdata;
    logic        cdb_rdy;
    logic [31:0] cdb_result;
    logic [3:0]  cdb_tag;
    logic [31:0] ld_cnt, st_cnt, busy_cnt;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  tag;
    } exp_t;

    exp_t expQ[$];
    int   numChecks = 0;
    int   numErrors = 0;
    int   expLd = 0, expSt = 0, expBusy = 0;

    ls_ctrl dut (
        .clk_in             (clk),
        .rst_in             (rst_n),
        .rdy_in             (rdy),
        .refresh_rob_cdb_in (refresh),
        .rdy_lsb_in         (rdy_lsb),
        .opcode_lsb_in      (opcode),
        .vj_lsb_in          (vj),
        .vk_lsb_in          (vk),
        .imm_lsb_in         (imm),
        .rob_id_lsb_in      (rob_id_in),
        .idle_lsb_out       (idle_out),
        .req_mc_out         (req_out),
        .we_mc_out          (we_out),
        .addr_mc_out        (addr_out),
        .size_mc_out        (size_out),
        .wdata_mc_out       (wdata_out),
        .done_mc_in         (done),
        .rdata_mc_in        (rdata),
        .rdy_cdb_out        (cdb_rdy),
        .result_cdb_out     (cdb_result),
        .rob_id_cdb_out     (cdb_tag),
        .ld_cnt_out         (ld_cnt),
        .st_cnt_out         (st_cnt),
        .busy_cnt_out       (busy_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        numChecks++;
        if (act !== exp) begin
            numErrors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic isStore(input logic [3:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic logic [1:0] opSize(input logic [3:0] op);
        if (op == OP_LB || op == OP_LBU || op == OP_SB) return 2'd0;
        if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2'd1;
        return 2'd2;
    endfunction

    // Load result computed arithmetically: take the low bytes as an unsigned
    // number, and for signed loads subtract 2^n when the value is in the upper half.
    function automatic logic [31:0] loadResult(input logic [3:0] op, input logic [31:0] d);
        longint v;
        case (op)
            OP_LB:  begin v = d % 256;   if (v >= 128)   v = v - 256;   end
            OP_LBU: v = d % 256;
            OP_LH:  begin v = d % 65536; if (v >= 32768) v = v - 65536; end
            OP_LHU: v = d % 65536;
            OP_LW:  v = d;
            default: v = 0;
        endcase
        return v[31:0];
    endfunction

    // Monitor: every visible broadcast must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst_n && cdb_rdy) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_cdb", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("cdb_result", cdb_result, e.res);
                checkOutput("cdb_tag", {28'd0, cdb_tag}, {28'd0, e.tag});
            end
        end
    end

    // Issues one op, then plays memory: done arrives at the delay-th live edge
    // after issue. Flush is asserted at live edge flushAt (0 = never). A 4-cycle
    // rdy_in freeze is inserted before live edge freezeAt (0 = never).
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] off, input logic [3:0] tag, input int delay,
                                 input int flushAt, input int freezeAt, input logic [31:0] rd);
        int    guard;
        logic  flushed;
        logic [31:0] expAddr;
        guard = 0;
        while (!idle_out && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) checkOutput("idle_timeout", {31'd0, idle_out}, 32'd1);
        expAddr   = a + off;
        rdy_lsb   = 1'b1;
        opcode    = op;
        vj        = a;
        vk        = b;
        imm       = off;
        rob_id_in = tag;
        @(negedge clk);
        rdy_lsb = 1'b0;
        checkOutput("issue_req", {31'd0, req_out}, 32'd1);
        checkOutput("issue_idle", {31'd0, idle_out}, 32'd0);
        checkOutput("issue_we", {31'd0, we_out}, {31'd0, isStore(op)});
        checkOutput("issue_addr", addr_out, expAddr);
        checkOutput("issue_size", {30'd0, size_out}, {30'd0, opSize(op)});
        checkOutput("issue_wdata", wdata_out, b);
        flushed = 1'b0;
        for (int k = 1; k <= delay; k++) begin
            if (k == freezeAt) begin
                rdy = 1'b0;
                repeat (4) @(negedge clk);
                checkOutput("freeze_req", {31'd0, req_out}, 32'd1);
                checkOutput("freeze_addr", addr_out, expAddr);
                checkOutput("freeze_idle", {31'd0, idle_out}, 32'd0);
                rdy = 1'b1;
            end
            refresh = (k == flushAt);
            if (refresh) flushed = 1'b1;
            if (k == delay) begin
                done  = 1'b1;
                rdata = rd;
                if (!flushed) expQ.push_back('{res: loadResult(op, rd), tag: tag});
            end
            @(negedge clk);
            expBusy++;
            refresh = 1'b0;
            done    = 1'b0;
            if (k < delay) begin
                checkOutput("wait_req", {31'd0, req_out}, 32'd1);
                checkOutput("wait_idle", {31'd0, idle_out}, 32'd0);
            end
        end
        checkOutput("done_req", {31'd0, req_out}, 32'd0);
        checkOutput("done_idle", {31'd0, idle_out}, 32'd1);
        if (!flushed) begin
            if (isStore(op)) expSt++;
            else expLd++;
        end
    endtask

    task automatic checkCounters(input string tagName);
`ifdef LSC_PERF_CNT_EN
        checkOutput({tagName, "_ld"}, ld_cnt, expLd);
        checkOutput({tagName, "_st"}, st_cnt, expSt);
        checkOutput({tagName, "_busy"}, busy_cnt, expBusy);
`else
        checkOutput({tagName, "_ld"}, ld_cnt, 32'd0);
        checkOutput({tagName, "_st"}, st_cnt, 32'd0);
        checkOutput({tagName, "_busy"}, busy_cnt, 32'd0);
`endif
    endtask

    // Global time limit so the bench can never hang.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] rop;
        int         d, f, z;
        rst_n = 1'b0; rdy = 1'b1; refresh = 1'b0; rdy_lsb = 1'b0; opcode = '0;
        vj = '0; vk = '0; imm = '0; rob_id_in = '0; done = 1'b0; rdata = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_idle", {31'd0, idle_out}, 32'd1);
        checkOutput("rst_req", {31'd0, req_out}, 32'd0);
        checkOutput("rst_cdb", {31'd0, cdb_rdy}, 32'd0);
        checkOutput("rst_addr", addr_out, 32'd0);
        checkCounters("rst_cnt");
        rst_n = 1'b1;
        @(negedge clk);

        applyStimulus(OP_LB, 32'h100, 32'h0, 32'hFFFF_FFFC, 4'd3, 1, 0, 0, 32'h80);
        checkOutput("lb_cdb_one_cycle", {31'd0, cdb_rdy}, 32'd1);
        @(negedge clk);
        applyStimulus(OP_SW, 32'h200, 32'hDEAD_BEEF, 32'd8, 4'd9, 3, 0, 0, 32'h1234_5678);
        applyStimulus(OP_LW, 32'h40, 32'h0, 32'h4, 4'd5, 3, 1, 0, 32'hCAFE_F00D);
        applyStimulus(OP_LH, 32'h10, 32'h0, 32'h2, 4'd6, 2, 0, 1, 32'h0000_8001);
        applyStimulus(OP_SH, 32'h30, 32'h5555, 32'h2, 4'd7, 2, 2, 0, 32'h0);

        // Flush in IDLE drops a simultaneous issue.
        @(negedge clk);
        rdy_lsb = 1'b1; refresh = 1'b1; opcode = OP_LW; rob_id_in = 4'd1;
        @(negedge clk);
        rdy_lsb = 1'b0; refresh = 1'b0;
        checkOutput("idle_flush_idle", {31'd0, idle_out}, 32'd1);
        checkOutput("idle_flush_req", {31'd0, req_out}, 32'd0);

        // Reset in the middle of a transaction.
        rdy_lsb = 1'b1; opcode = OP_LBU; vj = 32'h77; imm = 32'h1; rob_id_in = 4'd2;
        @(posedge clk);
        #2 rdy_lsb = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_req", {31'd0, req_out}, 32'd0);
        checkOutput("midrst_idle", {31'd0, idle_out}, 32'd1);
        checkOutput("midrst_addr", addr_out, 32'd0);
        expLd = 0; expSt = 0; expBusy = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Three loads and two stores with single-cycle memory.
        applyStimulus(OP_LB,  32'h0, 32'h0, 32'h0, 4'd1, 1, 0, 0, 32'hFF);
        applyStimulus(OP_SB,  32'h4, 32'h1, 32'h0, 4'd2, 1, 0, 0, 32'h0);
        applyStimulus(OP_LHU, 32'h8, 32'h0, 32'h0, 4'd3, 1, 0, 0, 32'hF00F);
        applyStimulus(OP_SW,  32'hC, 32'h2, 32'h0, 4'd4, 1, 0, 0, 32'h0);
        applyStimulus(OP_LW,  32'h10, 32'h0, 32'h0, 4'd5, 1, 0, 0, 32'h1);
        @(negedge clk);
        checkCounters("perf5");

        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 7));
            d   = $urandom_range(1, 4);
            f   = ($urandom_range(0, 3) == 0) ? $urandom_range(1, d) : 0;
            z   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, d) : 0;
            applyStimulus(rop, $urandom, $urandom, $urandom, 4'($urandom), d, f, z, $urandom);
        end
        repeat (3) @(negedge clk);
        checkCounters("final_cnt");
        checkOutput("queue_empty", expQ.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
        $finish;
    end

endmodule
